// File: rtl/alu_sequencer.sv
// alu_sequencer: drives one ALU datapath operation (A, B, latch, read) per handshaked request
module alu_sequencer #(
  parameter int WIDTH    = 16,
  parameter int OP_WIDTH = 3,
  parameter int SETTLE   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic [OP_WIDTH-1:0] reqOp,
  input  logic [WIDTH-1:0]    reqA,
  input  logic [WIDTH-1:0]    reqB,
  output logic                rspValid,
  input  logic                rspReady,
  output logic [WIDTH-1:0]    rspData,
  output logic [WIDTH-1:0]    busDrive,
  input  logic [WIDTH-1:0]    busSample,
  output logic [OP_WIDTH-1:0] opControl,
  output logic                ALUin0,
  output logic                ALUin1,
  output logic                ALUOutLatch,
  output logic                ALUOutEn,
  output logic                busy
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LOAD = CW'(SETTLE - 1);
  typedef enum logic [2:0] {IDLE, DRIVE_A, LATCH_A, DRIVE_B, LATCH_B, LATCH_OUT, READ_OUT, RESP} state_t;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_bus;
  logic              r_drv;
  // The bus is released before the result strobes so the datapath can own it.
  assign busDrive = r_drv ? r_bus : 'z;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_b         <= '0;
      r_bus       <= '0;
      r_drv       <= 1'b0;
      reqReady    <= 1'b1;
      rspValid    <= 1'b0;
      rspData     <= '0;
      opControl   <= '0;
      ALUin0      <= 1'b0;
      ALUin1      <= 1'b0;
      ALUOutLatch <= 1'b0;
      ALUOutEn    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (reqValid && reqReady) begin
          r_bus     <= reqA;
          r_b       <= reqB;
          r_drv     <= 1'b1;
          opControl <= reqOp;
          reqReady  <= 1'b0;
          busy      <= 1'b1;
          r_cnt     <= LOAD;
          r_state   <= DRIVE_A;
        end
        DRIVE_A: if (r_cnt == '0) begin
          ALUin0  <= 1'b1;
          r_state <= LATCH_A;
        end else r_cnt <= r_cnt - 1'b1;
        LATCH_A: begin
          ALUin0  <= 1'b0;
          r_bus   <= r_b;
          r_cnt   <= LOAD;
          r_state <= DRIVE_B;
        end
        DRIVE_B: if (r_cnt == '0) begin
          ALUin1  <= 1'b1;
          r_state <= LATCH_B;
        end else r_cnt <= r_cnt - 1'b1;
        LATCH_B: begin
          ALUin1      <= 1'b0;
          ALUOutLatch <= 1'b1;
          r_drv       <= 1'b0;
          r_state     <= LATCH_OUT;
        end
        LATCH_OUT: begin
          ALUOutLatch <= 1'b0;
          ALUOutEn    <= 1'b1;
          r_state     <= READ_OUT;
        end
        READ_OUT: begin
          ALUOutEn  <= 1'b0;
          rspData   <= busSample;
          rspValid  <= 1'b1;
          opControl <= '0;
          r_state   <= RESP;
        end
        RESP: if (rspReady) begin
          rspValid <= 1'b0;
          reqReady <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random requests through the sequencer against a behavioural ALU datapath
module tb_alu_sequencer;
  localparam int W = 16;
  localparam int S = 2;
  logic clk = 0, rst = 0, reqValid = 0, rspReady = 0;
  logic [2:0] reqOp = 0;
  logic [W-1:0] reqA = 0, reqB = 0;
  logic reqReady, rspValid, ALUin0, ALUin1, ALUOutLatch, ALUOutEn, busy;
  logic [W-1:0] rspData, busSample, dp_a, dp_b, dp_r, last_rsp;
  logic [2:0] opControl;
  logic [3:0] prev_str;
  tri1 [W-1:0] w_bus;
  int total = 0, bad = 0;
  alu_sequencer #(.WIDTH(W), .OP_WIDTH(3), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
    .reqA(reqA), .reqB(reqB), .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .busDrive(w_bus), .busSample(busSample), .opControl(opControl), .ALUin0(ALUin0),
    .ALUin1(ALUin1), .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a;
      default: return b;
    endcase
  endfunction
  // Datapath model: operand registers, result register, result driven only under ALUOutEn.
  always @(posedge clk) begin
    if (ALUin0) dp_a <= w_bus;
    if (ALUin1) dp_b <= w_bus;
    if (ALUOutLatch) dp_r <= ref_alu(opControl, dp_a, dp_b);
  end
  assign busSample = ALUOutEn ? dp_r : '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      if (ALUOutEn) chk("contention", w_bus, 32'hFFFF);
      if ({ALUin0, ALUin1, ALUOutLatch, ALUOutEn} != 0) begin
        chk("onehot", $countones({ALUin0, ALUin1, ALUOutLatch, ALUOutEn}), 1);
        chk("pulse", prev_str & {ALUin0, ALUin1, ALUOutLatch, ALUOutEn}, 0);
      end
    end
    prev_str <= {ALUin0, ALUin1, ALUOutLatch, ALUOutEn};
  end
  task automatic check_idle(input string tag);
    chk({tag, "_str"}, {ALUin0, ALUin1, ALUOutLatch, ALUOutEn}, 0);
    chk({tag, "_bus"}, w_bus, 32'hFFFF);
    chk({tag, "_rdy"}, reqReady, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vld"}, rspValid, 0);
    chk({tag, "_data"}, rspData, 0);
    chk({tag, "_op"}, opControl, 0);
  endtask
  // Called at a negedge with a request already presented; runs it to completion.
  task automatic seq(input int bp, input logic nv, input logic [2:0] nop, input logic [W-1:0] na, nb);
    logic [2:0] op;
    logic [W-1:0] a, b, r;
    int w;
    w = 0;
    rspReady = (bp == 0);
    while (!(reqReady && reqValid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    op = reqOp; a = reqA; b = reqB; r = ref_alu(op, a, b);
    @(posedge clk);
    #1 reqValid = nv; reqOp = nop; reqA = na; reqB = nb;
    for (int k = 1; k <= 2 * S + 5; k++) begin
      @(negedge clk);
      chk("ain0", ALUin0, k == S + 1);
      chk("ain1", ALUin1, k == 2 * S + 2);
      chk("olatch", ALUOutLatch, k == 2 * S + 3);
      chk("oen", ALUOutEn, k == 2 * S + 4);
      chk("bus", w_bus, k <= S + 1 ? a : k <= 2 * S + 2 ? b : 16'hFFFF);
      chk("opctl", opControl, k <= 2 * S + 4 ? op : 3'd0);
      chk("rdy_busy", reqReady, 0);
      chk("busy", busy, 1);
      chk("rsp_valid", rspValid, k == 2 * S + 5);
    end
    chk("rsp_data", rspData, r);
    last_rsp = rspData;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", rspValid, 1);
      chk("bp_data", rspData, r);
      chk("bp_rdy", reqReady, 0);
      chk("bp_str", {ALUin0, ALUin1, ALUOutLatch, ALUOutEn}, 0);
    end
    rspReady = 1;
    @(negedge clk);
    chk("back_idle", reqReady, 1);
    chk("back_vld", rspValid, 0);
    chk("back_busy", busy, 0);
    rspReady = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1;
    @(negedge clk);
    check_idle("post_reset");
    reqValid = 1; reqOp = 3'd2; reqA = 16'hAAAA; reqB = 16'h5555;
    @(posedge clk);
    #1 reqValid = 0;
    repeat (S + 1) @(posedge clk);
    #1 chk("t1_in_b", w_bus, 16'h5555);
    rst = 0;
    @(negedge clk);
    check_idle("t1_abort");
    rst = 1;
    @(negedge clk);
    check_idle("t1_release");
    reqValid = 1; reqOp = 3'd0; reqA = 16'h00FF; reqB = 16'h12C8;
    seq(0, 0, 3'd0, '0, '0);
    chk("t2_result", last_rsp, 16'h13C7);
    reqValid = 1; reqOp = 3'd0; reqA = 16'h00FF; reqB = 16'h12C8;
    seq(20, 0, 3'd0, '0, '0);
    chk("t3_result", last_rsp, 16'h13C7);
    reqValid = 1; reqOp = 3'd3; reqA = 16'h5A5A; reqB = 16'h0F0F;
    seq(3, 1, 3'd1, 16'h0001, 16'h8000);
    chk("t4_first", last_rsp, 16'h5F5F);
    seq(0, 0, 3'd0, '0, '0);
    chk("t4_second", last_rsp, 16'h8001);
    for (int n = 0; n < 50; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      reqValid = 1;
      reqOp = 3'($urandom_range(0, 7));
      reqA = W'($urandom);
      reqB = W'($urandom);
      seq($urandom_range(0, 3), 0, 3'd0, '0, '0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end
endmodule
